// File: rtl/log_pkg.sv
// Shared definitions for the sequential floor-log2 unit.
//   BYTE_W           : width of one scan step
//   IDX_W            : width of the byte index (covers up to 8 bytes)
//   log2_seq_state_t : controller states
//   res_width()      : result width for an operand of a given byte count
package log_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } log2_seq_state_t;

  function automatic int unsigned res_width(input int unsigned bytes);
    return $clog2(bytes * BYTE_W);
  endfunction

endpackage

// File: rtl/log8_core.sv
// Combinational 8-bit floor-log2.
//   data_i   : byte to encode
//   result_o : index of the highest set bit, 0 when data_i is 0
module log8_core (
  input  logic [7:0] data_i,
  output logic [2:0] result_o
);

  always_comb begin
    result_o = 3'd0;
    for (int unsigned b = 0; b < 8; b++) begin
      // Later (higher) bits overwrite, so the highest set bit wins.
      if (data_i[b]) result_o = 3'(b);
    end
  end

endmodule

// File: rtl/log2_seq.sv
// Multi-cycle floor-log2 for a BYTES*8-bit operand. The operand is scanned one byte per
// cycle, most-significant byte first, through a single shared 8-bit log core.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid_i   : operand offered
//   in_ready_o   : unit idle and able to accept an operand
//   in_data_i    : operand
//   out_valid_o  : result available (held until out_ready_i)
//   out_ready_i  : consumer accepts the result
//   out_result_o : floor(log2(operand)), 0 for a zero operand
//   out_zero_o   : operand was zero
module log2_seq
  import log_pkg::*;
#(
  parameter int unsigned BYTES  = 4,
  parameter int unsigned DATA_W = BYTES * BYTE_W,
  parameter int unsigned RES_W  = res_width(BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RES_W-1:0]  out_result_o,
  output logic              out_zero_o
);

  log2_seq_state_t   state_q, state_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              zero_q, zero_d;

  logic [BYTE_W-1:0] cur_byte;
  logic [2:0]        core_res;

  // Byte mux: select operand byte idx_q for the shared core.
  always_comb begin
    cur_byte = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (idx_q == IDX_W'(b)) cur_byte = operand_q[b*BYTE_W +: BYTE_W];
    end
  end

  log8_core u_log8_core (
    .data_i   (cur_byte),
    .result_o (core_res)
  );

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    idx_d     = idx_q;
    result_d  = result_q;
    zero_d    = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          operand_d = in_data_i;
          idx_d     = IDX_W'(BYTES - 1);
          state_d   = StScan;
        end
      end
      StScan: begin
        if (cur_byte != '0) begin
          // idx*8 + core_res is a plain concatenation; max value DATA_W-1 fits RES_W.
          result_d = RES_W'({idx_q, core_res});
          zero_d   = 1'b0;
          state_d  = StDone;
        end else if (idx_q == '0) begin
          result_d = '0;
          zero_d   = 1'b1;
          state_d  = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      operand_q <= '0;
      idx_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign out_valid_o  = (state_q == StDone);
  assign out_result_o = result_q;
  assign out_zero_o   = zero_q;

endmodule

// File: tb/tb_log2_seq.sv
// Self-checking bench for log2_seq (BYTES=4): directed scenarios plus randomized operands
// checked against a bit-scan reference model.
module tb_log2_seq;

  localparam int unsigned BYTES  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 5;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
  logic              out_zero;

  int n_checks;
  int n_fail;

  log2_seq #(
    .BYTES (BYTES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_zero_o   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: position of the highest set bit, 0 for zero.
  function automatic int ref_log2(input logic [DATA_W-1:0] x);
    for (int i = DATA_W - 1; i >= 0; i--) if (x[i]) return i;
    return 0;
  endfunction

  // Scan length: one cycle per byte from the top down to the highest nonzero byte.
  function automatic int ref_lat(input logic [DATA_W-1:0] x);
    int k;
    k = (x == '0) ? 0 : ref_log2(x) / 8;
    return BYTES - k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer d, measure edges until out_valid, then complete the output handshake.
  // rnd_ready randomizes out_ready while DONE and checks the outputs stay stable.
  task automatic run_op(input logic [DATA_W-1:0] d, input bit rnd_ready, output int lat,
                        output logic [RES_W-1:0] res, output logic z);
    int  guard;
    bit  done;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res   = out_result;
    z     = out_zero;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (guard >= 30) out_ready = 1'b1;
      tick();
      guard++;
      if (out_ready) begin
        done = 1'b1;
      end else begin
        check("hold_valid", out_valid, 1);
        check("hold_result", out_result, res);
        check("hold_zero", out_zero, z);
      end
    end
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_ready", in_ready, 1);
  endtask

  initial begin
    int               lat;
    logic [RES_W-1:0] res;
    logic             z;
    logic [DATA_W-1:0] d;
    int               guard;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_zero", out_zero, 0);
    rst_n = 1'b1;
    tick();

    // Directed operands
    run_op(32'h8000_0000, 1'b0, lat, res, z);
    check("msb_res", res, 31);
    check("msb_zero", z, 0);
    check("msb_lat", lat, 1);

    run_op(32'h0001_2345, 1'b0, lat, res, z);
    check("b2_res", res, 16);
    check("b2_zero", z, 0);
    check("b2_lat", lat, 2);

    run_op(32'h0000_0001, 1'b0, lat, res, z);
    check("one_res", res, 0);
    check("one_zero", z, 0);
    check("one_lat", lat, 4);

    run_op(32'h0000_0000, 1'b0, lat, res, z);
    check("zero_res", res, 0);
    check("zero_zero", z, 1);
    check("zero_lat", lat, 4);

    // Back-pressure with a second operand pending
    in_valid = 1'b1;
    in_data  = 32'h0000_0F00;
    tick();
    in_data = 32'hFFFF_FFFF;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("bp_scan_in_ready", in_ready, 0);
      tick();
      lat++;
    end
    check("bp_lat", lat, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", out_result, 11);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_handshake_idle", in_ready, 1);
    check("bp_handshake_valid", out_valid, 0);
    tick();
    check("bp_second_accepted", in_ready, 0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_second_lat", lat, 1);
    check("bp_second_res", out_result, 31);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during SCAN
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_mid_scanning", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_no_result", out_valid, 0);
    run_op(32'h0000_0080, 1'b0, lat, res, z);
    check("post_rst_res", res, 7);
    check("post_rst_zero", z, 0);
    check("post_rst_lat", lat, 4);

    // Randomized operands with random back-pressure
    for (int n = 0; n < 3000; n++) begin
      d = $urandom;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 1) == 0) d[b*8 +: 8] = 8'h00;
      run_op(d, 1'b1, lat, res, z);
      check("rnd_res", res, ref_log2(d));
      check("rnd_zero", z, (d == '0));
      check("rnd_lat", lat, ref_lat(d));
    end

    guard = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
